// File: rtl/translator_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ page-translation requesters onto one shared
// translator, keeping a single translation in flight and forcing a fault on timeout.
`ifndef DCP_PADDR
`define DCP_PADDR 40
`endif

module translator_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PN_W    = `DCP_PADDR - 12,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*PN_W-1:0] req_vpn_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    tr_req_valid_o,
    input  logic                    tr_req_ready_i,
    output logic [PN_W-1:0]         tr_req_vpn_o,
    input  logic                    tr_resp_valid_i,
    input  logic [PN_W-1:0]         tr_resp_ppn_i,
    input  logic                    tr_resp_fault_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    input  logic [NUM_REQ-1:0]      resp_ready_i,
    output logic [PN_W-1:0]         resp_ppn_o,
    output logic                    resp_fault_o,
    output logic                    resp_timeout_o,
    output logic                    busy_o
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_found;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] id_oh;
    logic [PN_W-1:0]    vpn_arr [NUM_REQ];
    logic [PN_W-1:0]    vpn_q;
    logic [PN_W-1:0]    ppn_q;
    logic               fault_q;
    logic               timeout_q;
    logic               tr_req_valid_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [CNT_W-1:0]   cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_vpn_slice
        assign vpn_arr[g] = req_vpn_i[g*PN_W +: PN_W];
    end

    // Scan starts at rr_ptr and wraps, so the last served requester has lowest priority.
    always_comb begin : grant_scan
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_found && req_valid_i[ID_W'(idx)]) begin
                gnt_found             = 1'b1;
                gnt_id                = ID_W'(idx);
                gnt_oh[ID_W'(idx)]    = 1'b1;
            end
        end
    end

    always_comb begin
        id_oh       = '0;
        id_oh[id_q] = 1'b1;
    end

    assign req_ready_o    = (state == IDLE && !rst_i) ? gnt_oh : '0;
    assign tr_req_valid_o = tr_req_valid_q;
    assign tr_req_vpn_o   = tr_req_valid_q ? vpn_q : '0;
    assign resp_valid_o   = resp_valid_q;
    assign resp_ppn_o     = ppn_q;
    assign resp_fault_o   = fault_q;
    assign resp_timeout_o = timeout_q;
    assign busy_o         = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            id_q           <= '0;
            vpn_q          <= '0;
            ppn_q          <= '0;
            fault_q        <= 1'b0;
            timeout_q      <= 1'b0;
            tr_req_valid_q <= 1'b0;
            resp_valid_q   <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        vpn_q          <= vpn_arr[gnt_id];
                        id_q           <= gnt_id;
                        tr_req_valid_q <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tr_req_ready_i) begin
                        tr_req_valid_q <= 1'b0;
                        cnt            <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != CNT_W'(TIMEOUT)) begin
                        cnt <= cnt + 1'b1;
                    end
                    // A response landing on the final count beats the timeout.
                    if (tr_resp_valid_i) begin
                        ppn_q        <= tr_resp_ppn_i;
                        fault_q      <= tr_resp_fault_i;
                        timeout_q    <= 1'b0;
                        resp_valid_q <= id_oh;
                        state        <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        ppn_q        <= '0;
                        fault_q      <= 1'b1;
                        timeout_q    <= 1'b1;
                        resp_valid_q <= id_oh;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i[id_q]) begin
                        resp_valid_q <= '0;
                        ppn_q        <= '0;
                        fault_q      <= 1'b0;
                        timeout_q    <= 1'b0;
                        rr_ptr       <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/translator_arbiter.md
TRANSLATOR_ARBITER -- requirements
Module: translator_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of page-translation requesters (2..8).
REQ-002 Parameter PN_W, default `DCP_PADDR-12, page-number width; identical to translator_pkg::pn_t.
REQ-003 Parameter TIMEOUT, default 1023, maximum WAIT-state cycles before forced fault (1..65535).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset; asynchronous assert, active-high.
REQ-006 req_valid_i  input  NUM_REQ  per-requester translation request valid.
REQ-007 req_vpn_i  input  NUM_REQ*PN_W  per-requester virtual page number; slice i = bits [i*PN_W +: PN_W].
REQ-008 req_ready_o  output  NUM_REQ  one-hot acceptance of a request.
REQ-009 tr_req_valid_o  output  1  request valid to the shared translator.
REQ-010 tr_req_ready_i  input  1  translator accepts request.
REQ-011 tr_req_vpn_o  output  PN_W  latched virtual page number.
REQ-012 tr_resp_valid_i  input  1  translator response valid (single-cycle pulse, no backpressure).
REQ-013 tr_resp_ppn_i  input  PN_W  physical page number.
REQ-014 tr_resp_fault_i  input  1  translation fault.
REQ-015 resp_valid_o  output  NUM_REQ  one-hot response valid to the owning requester.
REQ-016 resp_ready_i  input  NUM_REQ  per-requester response accept.
REQ-017 resp_ppn_o  output  PN_W  latched physical page number (shared bus).
REQ-018 resp_fault_o  output  1  fault flag (translator fault or timeout).
REQ-019 resp_timeout_o  output  1  fault caused by timeout.
REQ-020 busy_o  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; one translation outstanding at a time.
REQ-022 IDLE: if any req_valid_i set, grant = first set bit at or above rr_ptr, wrapping modulo NUM_REQ; req_ready_o[grant]=1 combinationally that cycle; latch vpn and grant id; next state ISSUE.
REQ-023 IDLE with no valid requests: all outputs deasserted, state held.
REQ-024 req_ready_o is zero in all states except IDLE; never more than one bit set.
REQ-025 ISSUE: tr_req_valid_o=1, tr_req_vpn_o=latched vpn, held stable until tr_req_ready_i; on handshake go WAIT, clear timeout counter.
REQ-026 WAIT: counter increments each cycle; on tr_resp_valid_i latch ppn and fault, resp_timeout=0, go RESP.
REQ-027 WAIT timeout: when counter reaches TIMEOUT without response, latch ppn=0, fault=1, timeout=1, go RESP; counter width ceil(log2(TIMEOUT+1)), saturating, no wrap.
REQ-028 Response and timeout in same cycle: response wins, timeout flag 0.
REQ-029 tr_resp_valid_i outside WAIT is ignored; no state or latch change.
REQ-030 RESP: resp_valid_o[id]=1, resp_ppn_o/resp_fault_o/resp_timeout_o stable; on resp_ready_i[id] go IDLE and set rr_ptr=(id+1) mod NUM_REQ; resp_ready_i of other bits ignored.
REQ-031 Minimum latency: request accept (cycle 0) -> tr_req_valid_o cycle 1 -> response at cycle 2 earliest -> resp_valid_o cycle 3; back-to-back grant earliest the cycle after the resp handshake.
REQ-032 resp_ppn_o/resp_fault_o/resp_timeout_o are zero outside RESP.
REQ-033 A requester dropping req_valid_i before grant is not granted; inputs after grant do not affect the latched vpn.

Reset
REQ-034 rst_i assertion asynchronously forces IDLE, rr_ptr=0, counter=0, latches=0; all outputs 0 while rst_i high.
REQ-035 Reset mid-transaction abandons it with no response generated; first grant after release follows rr_ptr=0.

Verification
REQ-036 Single request: NUM_REQ=4, req_valid_i=4'b0100, vpn=0x123, translator ready immediately, responds ppn=0xABC next cycle -> req_ready_o=4'b0100 cycle 0, resp_valid_o=4'b0100 with ppn 0xABC cycle 3, fault 0.
REQ-037 Round-robin: all four requesters valid continuously -> grants in order 0,1,2,3,0; no requester granted twice before all others.
REQ-038 Backpressure: tr_req_ready_i low 5 cycles, resp_ready_i low 3 cycles -> tr_req_vpn_o and resp_ppn_o stable throughout, no new grant.
REQ-039 Timeout: TIMEOUT=8, no translator response -> resp_valid_o asserted after 8 WAIT cycles with fault=1, timeout=1, ppn=0.
REQ-040 Collision: response arrives on the cycle counter reaches TIMEOUT -> translator ppn delivered, timeout=0; stray tr_resp_valid_i in IDLE ignored.
REQ-041 Reset in WAIT: assert rst_i mid-WAIT -> outputs 0 immediately, no resp_valid_o, next grant goes to lowest-index valid requester.
